alu_mul_sequencer: RTL

//  Multi-cycle controller that runs an unsigned shift-add multiply (RV32M MUL, low word) on the

---
 rtl/alu_mul_sequencer.sv | 71 +++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiply (low word) driven through the shared EX-stage ALU
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_own,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             in_run, last;
  always_comb begin
    in_run  = state == RUN;
    last    = cnt == CW'(WIDTH - 1);
    acc_nxt = mplier[0] ? alu_result : acc;
    alu_own = in_run || state == DONE;
    stall   = alu_own;
    done    = state == DONE;
    alu_a   = in_run ? acc : '0;
    alu_b   = in_run ? mcand : '0;
    alu_op  = ALU_ADD;
  end
  // result is committed on the last iteration so it is valid alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          acc    <= '0;
          mcand  <= op_a;
          mplier <= op_b;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: if (flush) state <= IDLE;
        else begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= acc_nxt;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
